// File: rtl/if_stage.sv
// Instruction fetch stage for the in-order RV32I pipeline.
// Issues sequential word-aligned fetches, tags each request with its PC, and
// buffers returned words in a small in-order queue ahead of the decoder. A
// redirect flushes the queue and marks every in-flight response as stale.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [2:0]  CREDIT_LIMIT = 3'(DEPTH);

    // Fetch PC and credit bookkeeping
    logic [31:0] pc;
    logic [1:0]  outstanding;
    logic [1:0]  drop_cnt;

    // Instruction queue (two entries, in order)
    logic [31:0] q_pc   [2];
    logic [31:0] q_inst [2];
    logic [1:0]  count;
    logic        head;
    logic        tail;

    // PC tags of live (non-stale) requests, in request order
    logic [31:0] tag_pc [2];
    logic        tag_wr;
    logic        tag_rd;

    // Per-cycle events
    logic        req_fire;
    logic        resp_ok;
    logic        push;
    logic        pop;
    logic        have_entry;
    logic [2:0]  in_use;

    // Word-align a target address.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Next sequential fetch address; wraps naturally at 32 bits.
    function automatic logic [31:0] seq_pc(input logic [31:0] cur);
        return cur + 32'd4;
    endfunction

    // Two-bit counter update by independent +1 / -1 events.
    function automatic logic [1:0] bump(input logic [1:0] val,
                                        input logic       inc,
                                        input logic       dec);
        return val + {1'b0, inc} - {1'b0, dec};
    endfunction

    // Credit counts both requests in flight and words already queued, so a
    // returning response always has a free slot. Only registered state is
    // used: a pop this cycle frees its credit on the next cycle.
    assign in_use         = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = rst && !redirect_valid && (in_use < CREDIT_LIMIT);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    // Responses owed to pre-redirect requests (drop_cnt) and any response in
    // the redirect cycle itself are discarded.
    assign resp_ok = imem_resp_valid && (outstanding != 2'd0);
    assign push    = resp_ok && !redirect_valid && (drop_cnt == 2'd0);

    assign have_entry = (count != 2'd0);
    assign id_valid   = have_entry && !redirect_valid;
    assign pop        = id_valid && id_ready;
    assign id_inst    = have_entry ? q_inst[head] : NOP_INST;
    assign id_pc      = have_entry ? q_pc[head]   : 32'h0000_0000;

    // Fetch PC: redirect overrides sequential advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= align_pc(redirect_pc);
        end else if (req_fire) begin
            pc <= seq_pc(pc);
        end
    end

    // Requests in flight: +1 on fire, -1 on any accepted response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= 2'd0;
        end else begin
            outstanding <= bump(outstanding, req_fire, resp_ok);
        end
    end

    // Stale-response counter: reloaded on redirect with every request still
    // owed after this cycle, then counted down as those responses return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= 2'd0;
        end else if (redirect_valid) begin
            drop_cnt <= outstanding - {1'b0, resp_ok};
        end else if (resp_ok && (drop_cnt != 2'd0)) begin
            drop_cnt <= drop_cnt - 2'd1;
        end
    end

    // Queue occupancy and pointers; a redirect empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (redirect_valid) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            count <= bump(count, push, pop);
            if (push) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
        end
    end

    // Queue payload: written at tail with the tag of the oldest live request.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]   <= tag_pc[tag_rd];
            q_inst[tail] <= imem_resp_data;
        end
    end

    // Tag FIFO pointers; stale requests never read a tag, so a redirect
    // simply restarts both pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_wr <= 1'b0;
            tag_rd <= 1'b0;
        end else if (redirect_valid) begin
            tag_wr <= 1'b0;
            tag_rd <= 1'b0;
        end else begin
            if (req_fire) begin
                tag_wr <= ~tag_wr;
            end
            if (push) begin
                tag_rd <= ~tag_rd;
            end
        end
    end

    // Tag FIFO payload: PC of each issued request.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_pc[tag_wr] <= pc;
        end
    end

    // Protocol and occupancy sanity checks (simulation only).
    always @(posedge clk) begin
        if (rst) begin
            assert (!(imem_resp_valid && (outstanding == 2'd0)));
            assert (in_use <= CREDIT_LIMIT);
            assert (drop_cnt <= outstanding);
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed-plus-random bench for if_stage with a queue-based reference model
// of the fetch stream, in-flight requests and the decode-side buffer.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    if_stage #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit stale; }        fetch_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;
    typedef struct { logic [31:0] addr; int due; }         mreq_t;

    fetch_t      inflight[$];
    entry_t      fq[$];
    mreq_t       mem_q[$];
    logic [31:0] m_pc;
    int          cyc;
    int          lat;
    int          p_req_ready;
    int          p_id_ready;
    int          errors;
    int          checks;
    bit          pop_seen;
    logic [31:0] last_pop_pc;
    bit          found;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, update model after posedge.
    task automatic step(input bit redir, input logic [31:0] rpc);
        bit          rq_rdy;
        bit          idr;
        bit          rv;
        bit          exp_rv;
        bit          exp_idv;
        bit          fire;
        bit          pop;
        int          c0;
        fetch_t      f;
        mreq_t       mq;
        logic [31:0] rdata;

        rq_rdy = (int'($urandom_range(99)) < p_req_ready);
        idr    = (int'($urandom_range(99)) < p_id_ready);
        rv     = rst && (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        rdata  = rv ? mem_word(mem_q[0].addr) : $urandom;

        imem_req_ready  = rq_rdy;
        id_ready        = idr;
        imem_resp_valid = rv;
        imem_resp_data  = rdata;
        redirect_valid  = redir;
        redirect_pc     = rpc;
        #4;

        exp_rv  = rst && !redir && ((inflight.size() + fq.size()) < 2);
        exp_idv = (fq.size() != 0) && !redir;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("id_valid", 32'(id_valid), 32'(exp_idv));
        chk("id_inst", id_inst, (fq.size() != 0) ? fq[0].inst : NOP_INST);
        chk("id_pc", id_pc, (fq.size() != 0) ? fq[0].pc : 32'h0);

        fire = exp_rv && rq_rdy;
        pop  = exp_idv && idr;
        if (pop) begin
            pop_seen    = 1'b1;
            last_pop_pc = id_pc;
        end
        c0 = cyc;

        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            if (pop) void'(fq.pop_front());
            if (rv) begin
                f  = inflight.pop_front();
                mq = mem_q.pop_front();
                if (!f.stale && !redir) fq.push_back('{f.pc, mem_word(f.pc)});
            end
            if (fire) begin
                inflight.push_back('{m_pc, 1'b0});
                mem_q.push_back('{m_pc, c0 + lat});
                m_pc = m_pc + 32'd4;
            end
            if (redir) begin
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                fq.delete();
                m_pc = {rpc[31:2], 2'b00};
            end
        end
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] exp);
        pop_seen = 1'b0;
        for (int i = 0; i < 30 && !pop_seen; i++) step(1'b0, 32'h0);
        chk({tag, "_timeout"}, 32'(pop_seen), 32'd1);
        chk(tag, pop_seen ? last_pop_pc : 32'hDEAD_BEEF, exp);
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; lat = 1;
        p_req_ready = 100; p_id_ready = 100;
        m_pc = RESET_PC; pop_seen = 1'b0; last_pop_pc = 32'h0; found = 1'b0;
        rst = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held for two cycles, then free-run at one-cycle latency
        repeat (2) step(1'b0, 32'h0);
        rst = 1'b1;
        wait_pop("first_pc_after_reset", RESET_PC);
        repeat (14) step(1'b0, 32'h0);

        // Decode stall fills the queue; release drains in order
        p_id_ready = 0;
        repeat (6) step(1'b0, 32'h0);
        p_id_ready = 100;
        repeat (8) step(1'b0, 32'h0);

        // Redirect with two requests in flight at latency 3
        lat = 3; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (inflight.size() == 2) found = 1'b1;
            else step(1'b0, 32'h0);
        end
        chk("two_in_flight_reached", 32'(found), 32'd1);
        step(1'b1, 32'h0000_0103);
        wait_pop("pc_after_redirect", 32'h0000_0100);

        // Redirect coincident with the only outstanding response
        lat = 2; p_req_ready = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (inflight.size() == 0 && fq.size() == 0) found = 1'b1;
            else step(1'b0, 32'h0);
        end
        chk("drained_before_coincident", 32'(found), 32'd1);
        p_req_ready = 100;
        step(1'b0, 32'h0);
        p_req_ready = 0;
        step(1'b0, 32'h0);
        chk("resp_due_in_redirect_cycle",
            32'(inflight.size() == 1 && mem_q.size() == 1 && mem_q[0].due <= cyc), 32'd1);
        step(1'b1, 32'h0000_2000);
        p_req_ready = 100;
        wait_pop("pc_after_coincident_redirect", 32'h0000_2000);

        // Request backpressure with an empty queue
        p_req_ready = 0;
        step(1'b1, 32'h0000_3002);
        repeat (4) step(1'b0, 32'h0);
        p_req_ready = 100;
        wait_pop("pc_after_backpressure", 32'h0000_3000);

        // Randomised traffic including the 32-bit PC wrap
        step(1'b1, 32'hFFFF_FFF8);
        wait_pop("pc_near_wrap", 32'hFFFF_FFF8);
        p_req_ready = 70; p_id_ready = 70;
        repeat (400) begin
            lat = int'($urandom_range(4, 1));
            step(int'($urandom_range(99)) < 5, $urandom);
        end

        // Asynchronous reset between edges with queued and in-flight work
        lat = 3; p_req_ready = 100; p_id_ready = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (fq.size() >= 1 && inflight.size() >= 1) found = 1'b1;
            else step(1'b0, 32'h0);
        end
        chk("busy_before_async_reset", 32'(found), 32'd1);
        imem_resp_valid = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0; imem_req_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_inst", id_inst, NOP_INST);
        chk("rst_id_pc", id_pc, 32'h0);
        inflight.delete(); fq.delete(); mem_q.delete(); m_pc = RESET_PC;
        @(posedge clk);
        #1;
        cyc++;
        step(1'b0, 32'h0);
        rst = 1'b1; p_id_ready = 100; lat = 1;
        wait_pop("pc_after_async_reset", RESET_PC);
        repeat (8) step(1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
